fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Upstream neighbour of the instruction memory: owns the program counter, drives the 64-bit instruction address, waits out the memory read time, and captures the 32-bit instruction word.
- Presents the word with its PC to decode through a valid/ready handshake.
- Accepts PC redirects (taken B/CBZ) from the execute stage.
- Flags the end of the program and misaligned redirect targets.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- READ_CYCLES, 2, clock edges the address is held before the data is sampled; legal range 1..15.
- PC_LIMIT, 64'h64, first byte address past the program; a PC >= PC_LIMIT ends fetching.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- imem_addr  output  64  instruction memory address; always equals the current PC.
- imem_data  input  32  instruction memory read data.
- instr  output  32  captured instruction word.
- instr_pc  output  64  PC of the word in instr.
- instr_valid  output  1  instr and instr_pc are valid.
- instr_ready  input  1  decode accepts the word.
- redirect_valid  input  1  load a new PC.
- redirect_pc  input  64  redirect target.
- done  output  1  PC reached PC_LIMIT; fetching has stopped.
- fault  output  1  misaligned redirect received; sticky.

Behaviour:
- Reset (synchronous; Reset high at an edge), in one cycle:
  - State FETCH, PC=RESET_PC, wait counter cnt=0.
  - instr=0, instr_pc=0, instr_valid=0, done=0, fault=0.
  - Reset mid-operation discards any held word and any wait in progress.
- States: FETCH, HOLD, DONE, FAULT. imem_addr = PC in every state (combinational from the PC register).
- FETCH:
  - If cnt == READ_CYCLES-1: instr<=imem_data, instr_pc<=PC, instr_valid<=1, go to HOLD.
  - Otherwise cnt<=cnt+1.
  - The first instr_valid rises READ_CYCLES edges after the first edge with Reset low.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until the handshake.
  - On an edge with instr_ready=1: instr_valid<=0, cnt<=0, nextPC = PC+4 (64-bit modulo arithmetic).
  - If nextPC >= PC_LIMIT (unsigned compare): go to DONE, done<=1. Otherwise PC<=nextPC and go to FETCH.
- Redirect (redirect_valid=1 at an edge, in FETCH, HOLD or DONE):
  - If redirect_pc[1:0] != 0: go to FAULT, fault<=1, instr_valid<=0.
  - Else if redirect_pc >= PC_LIMIT: go to DONE, done<=1, instr_valid<=0.
  - Else: PC<=redirect_pc, cnt<=0, instr_valid<=0, done<=0, go to FETCH.
  - Redirect has priority over a same-cycle handshake: the held word counts as consumed and PC+4 is not applied.
  - Redirect has priority over a same-cycle capture in FETCH: nothing is captured.
- DONE:
  - instr_valid=0; PC holds; imem_data is ignored.
  - Only a redirect or Reset exits DONE.
- FAULT:
  - instr_valid=0, fault=1; redirect is ignored.
  - Only Reset exits FAULT.
- The handshake is accepted only when instr_valid=1; instr_ready is ignored in FETCH, DONE and FAULT.
- READ_CYCLES=1: capture on the first FETCH edge, giving one word per 2 cycles with instr_ready tied high.
- cnt is 4 bits wide.

Test Plan:
- Release reset with the standard program loaded, READ_CYCLES=2, instr_ready=1 -> imem_addr=0x0; instr=F84003E9, instr_pc=0 valid 2 edges after release; then 0x4 gives F84083EA; instr_valid pulses every 3 cycles.
- Hold instr_ready=0 for 5 cycles while at PC 0x14 -> instr=AA0B014A and instr_valid stay stable, imem_addr=0x14; ready high for 1 cycle -> next word 8A0A018C from 0x18.
- With PC=0x28 held in HOLD, assert redirect_valid with redirect_pc=0x1C and instr_ready=1 in the same cycle -> instr_valid drops; the next word is from 0x1C, not 0x2C.
- Accept the word at 0x60 with PC_LIMIT=0x64 -> done=1, instr_valid stays 0; then redirect to 0x0 -> done=0 and fetch restarts at 0x0.
- Redirect to 0x1E -> fault=1; a further redirect to 0x0 is ignored; Reset high for one edge -> fault=0, PC=0.
- Assert Reset while in FETCH with cnt=1 -> no capture occurs; after release the first instr_valid follows READ_CYCLES edges later with PC=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// waits out the memory read latency, captures the word and offers it to decode
// through a valid/ready handshake. It accepts redirects from execute, stops at
// the end of the program and locks up on a misaligned redirect target.
// READ_CYCLES must lie in 1..15 because the wait counter is 4 bits wide.
module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned READ_CYCLES = 2,
  parameter logic [63:0] PC_LIMIT    = 64'h64
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        done,
  output logic        fault
);

  localparam logic [3:0] LAST_CNT = 4'(READ_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [3:0]  cnt;
  logic        done_q;

  logic [63:0] pc_inc;
  logic        redirect_take;
  logic        redirect_misaligned;
  logic        redirect_beyond;
  logic        redirect_load;
  logic        handshake;
  logic        capture;
  logic        advance;

  // A redirect outranks both a same-cycle capture and a same-cycle handshake,
  // so every datapath event below is qualified with !redirect_take.
  assign pc_inc              = pc + 64'd4;
  assign redirect_take       = redirect_valid && (state != S_FAULT);
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redirect_beyond     = (redirect_pc >= PC_LIMIT);
  assign redirect_load       = redirect_take && !redirect_misaligned && !redirect_beyond;
  assign handshake           = (state == S_HOLD) && instr_ready && !redirect_take;
  assign capture             = (state == S_FETCH) && (cnt == LAST_CNT) && !redirect_take;
  assign advance             = handshake && (pc_inc < PC_LIMIT);

  assign imem_addr = pc;

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting to the current state first keeps every path assigned,
    // so no latch is inferred.
    state_next = state;
    unique case (state)
      S_FETCH, S_HOLD, S_DONE: begin
        if (redirect_take) begin
          if (redirect_misaligned) begin
            state_next = S_FAULT;
          end else if (redirect_beyond) begin
            state_next = S_DONE;
          end else begin
            state_next = S_FETCH;
          end
        end else if (capture) begin
          state_next = S_HOLD;
        end else if (handshake) begin
          state_next = advance ? S_FETCH : S_DONE;
        end
      end
      S_FAULT: state_next = S_FAULT;
    endcase
  end

  // Output decode.
  always_comb begin
    instr_valid = (state == S_HOLD);
    fault       = (state == S_FAULT);
    done        = done_q;
  end

  // PC, wait counter, captured word and the done flag.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc       <= RESET_PC;
      cnt      <= 4'd0;
      instr    <= 32'd0;
      instr_pc <= 64'd0;
      done_q   <= 1'b0;
    end else begin
      if (redirect_load) begin
        pc <= redirect_pc;
      end else if (advance) begin
        pc <= pc_inc;
      end

      if (redirect_load || handshake) begin
        cnt <= 4'd0;
      end else if ((state == S_FETCH) && !redirect_take && !capture) begin
        cnt <= cnt + 4'd1;
      end

      if (capture) begin
        instr    <= imem_data;
        instr_pc <= pc;
      end

      // done survives a later fault; only a good redirect or reset clears it.
      if (redirect_load) begin
        done_q <= 1'b0;
      end else if (state_next == S_DONE) begin
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC    = 64'h0;
  localparam int          READ_CYCLES = 2;
  localparam logic [63:0] PC_LIMIT    = 64'h64;

  logic        CLK;
  logic        Reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        done;
  logic        fault;

  int checks = 0;
  int errors = 0;
  bit compare_en = 0;

  logic [31:0] mem [32];

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .READ_CYCLES(READ_CYCLES),
    .PC_LIMIT   (PC_LIMIT)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .done          (done),
    .fault         (fault)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction memory: combinational read, recognisable filler past the array.
  assign imem_data = (imem_addr < 64'd128) ? mem[imem_addr[6:2]] : 32'hDEADBEEF;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a < 64'd128) return mem[a[6:2]];
    return 32'hDEADBEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_pc;
  int          m_waited;
  bit          m_valid;
  bit          m_done;
  bit          m_fault;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;

  always @(posedge CLK) begin
    if (Reset) begin
      m_pc = RESET_PC; m_waited = 0; m_valid = 0; m_done = 0; m_fault = 0;
      m_instr = 32'd0; m_ipc = 64'd0;
    end else if (m_fault) begin
      // locked until reset
    end else if (redirect_valid) begin
      m_valid = 0;
      if (redirect_pc % 4 != 0) m_fault = 1;
      else if (redirect_pc >= PC_LIMIT) m_done = 1;
      else begin
        m_pc = redirect_pc; m_waited = 0; m_done = 0;
      end
    end else if (m_done) begin
      // idle until redirect
    end else if (m_valid) begin
      if (instr_ready) begin
        m_valid = 0;
        m_waited = 0;
        if (m_pc + 64'd4 >= PC_LIMIT) m_done = 1;
        else m_pc = m_pc + 64'd4;
      end
    end else begin
      m_waited = m_waited + 1;
      if (m_waited == READ_CYCLES) begin
        m_valid = 1; m_instr = mem_word(m_pc); m_ipc = m_pc;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (compare_en) begin
      check("cmp_imem_addr", imem_addr, m_pc);
      check("cmp_valid", {63'd0, instr_valid}, {63'd0, m_valid});
      check("cmp_done", {63'd0, done}, {63'd0, m_done});
      check("cmp_fault", {63'd0, fault}, {63'd0, m_fault});
      check("cmp_instr", {32'd0, instr}, {32'd0, m_instr});
      check("cmp_instr_pc", instr_pc, m_ipc);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Accept every word until the one at target is held, then stop with ready low.
  task automatic advance_to(input logic [63:0] target);
    int n = 0;
    redirect_valid = 0;
    while (!(m_valid && m_ipc == target) && n < 200) begin
      instr_ready = m_valid;
      @(negedge CLK);
      n++;
    end
    instr_ready = 0;
    if (n >= 200) check("timeout_advance_to", 64'd0, target);
  endtask

  task automatic wait_valid();
    int n = 0;
    instr_ready = 0;
    redirect_valid = 0;
    while (!m_valid && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check("timeout_wait_valid", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] r;
    case ($urandom_range(0, 9))
      0: r = {$urandom(), $urandom()} & ~64'h3 | 64'($urandom_range(1, 3));
      1: r = PC_LIMIT + 64'($urandom_range(0, 50)) * 4;
      2: r = 64'hFFFF_FFFF_FFFF_FFFC;
      default: r = 64'($urandom_range(0, 24)) * 4;
    endcase
    return r;
  endfunction

  // ---------------- directed and random sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'hF84003E9;
    mem[1] = 32'hF84083EA;
    mem[5] = 32'hAA0B014A;
    mem[6] = 32'h8A0A018C;

    Reset = 1; instr_ready = 0; redirect_valid = 0; redirect_pc = 64'd0;
    @(negedge CLK);
    compare_en = 1;
    @(negedge CLK);
    check("reset_addr", imem_addr, 64'h0);
    check("reset_valid", {63'd0, instr_valid}, 64'd0);
    check("reset_done_fault", {62'd0, done, fault}, 64'd0);
    check("reset_instr", {32'd0, instr}, 64'd0);

    // Streaming with ready high: a word every 3 cycles.
    Reset = 0; instr_ready = 1;
    @(negedge CLK);
    check("first_edge_not_valid", {63'd0, instr_valid}, 64'd0);
    @(negedge CLK);
    check("first_valid", {63'd0, instr_valid}, 64'd1);
    check("first_instr", {32'd0, instr}, 64'hF84003E9);
    check("first_pc", instr_pc, 64'h0);
    @(negedge CLK);
    check("after_accept_valid", {63'd0, instr_valid}, 64'd0);
    check("after_accept_addr", imem_addr, 64'h4);
    @(negedge CLK);
    @(negedge CLK);
    check("second_instr", {32'd0, instr}, 64'hF84083EA);
    check("second_valid", {63'd0, instr_valid}, 64'd1);
    instr_ready = 0;

    // Back-pressure at 0x14.
    advance_to(64'h14);
    repeat (5) begin
      @(negedge CLK);
      check("stall_instr", {32'd0, instr}, 64'hAA0B014A);
      check("stall_valid", {63'd0, instr_valid}, 64'd1);
      check("stall_addr", imem_addr, 64'h14);
    end
    instr_ready = 1;
    @(negedge CLK);
    instr_ready = 0;
    check("post_stall_addr", imem_addr, 64'h18);
    wait_valid();
    check("post_stall_instr", {32'd0, instr}, 64'h8A0A018C);
    check("post_stall_pc", instr_pc, 64'h18);

    // Redirect beats a same-cycle handshake.
    advance_to(64'h28);
    redirect_valid = 1; redirect_pc = 64'h1C; instr_ready = 1;
    @(negedge CLK);
    redirect_valid = 0; instr_ready = 0;
    check("redir_valid_drop", {63'd0, instr_valid}, 64'd0);
    check("redir_addr", imem_addr, 64'h1C);
    wait_valid();
    check("redir_word_pc", instr_pc, 64'h1C);

    // End of program and restart.
    advance_to(64'h60);
    instr_ready = 1;
    @(negedge CLK);
    check("done_set", {63'd0, done}, 64'd1);
    check("done_addr", imem_addr, 64'h60);
    repeat (3) begin
      @(negedge CLK);
      check("done_stays_invalid", {62'd0, done, instr_valid}, 64'd2);
    end
    redirect_valid = 1; redirect_pc = 64'h0;
    @(negedge CLK);
    redirect_valid = 0; instr_ready = 0;
    check("restart_done", {63'd0, done}, 64'd0);
    check("restart_addr", imem_addr, 64'h0);
    wait_valid();
    check("restart_instr", {32'd0, instr}, 64'hF84003E9);

    // Aligned redirect past the limit ends fetching with the PC held.
    redirect_valid = 1; redirect_pc = 64'h100;
    @(negedge CLK);
    check("far_redirect_done", {63'd0, done}, 64'd1);
    check("far_redirect_addr", imem_addr, 64'h0);
    redirect_pc = 64'h4;
    @(negedge CLK);
    redirect_valid = 0;
    check("far_then_good_done", {63'd0, done}, 64'd0);
    check("far_then_good_addr", imem_addr, 64'h4);

    // Misaligned redirect is sticky until reset.
    advance_to(64'h8);
    redirect_valid = 1; redirect_pc = 64'h1E;
    @(negedge CLK);
    check("fault_set", {63'd0, fault}, 64'd1);
    check("fault_addr", imem_addr, 64'h8);
    redirect_pc = 64'h0;
    @(negedge CLK);
    redirect_valid = 0;
    check("fault_ignores_redirect", {63'd0, fault}, 64'd1);
    check("fault_ignores_addr", imem_addr, 64'h8);
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
    check("fault_cleared", {63'd0, fault}, 64'd0);
    check("fault_reset_addr", imem_addr, 64'h0);

    // Reset in the middle of a memory wait.
    @(negedge CLK);
    check("midwait_not_valid", {63'd0, instr_valid}, 64'd0);
    Reset = 1;
    @(negedge CLK);
    Reset = 0;
    check("midwait_no_capture", {63'd0, instr_valid}, 64'd0);
    @(negedge CLK);
    check("midwait_one_edge", {63'd0, instr_valid}, 64'd0);
    @(negedge CLK);
    check("midwait_valid", {63'd0, instr_valid}, 64'd1);
    check("midwait_pc", instr_pc, RESET_PC);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      Reset          = ($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 7) == 0);
      instr_ready    = $urandom_range(0, 1) == 1;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc    = rand_target();
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
